// File: rtl/bram_sdp_if.sv
// bram_sdp_if: write/read/status bundle for bram_sdp.
// master drives requests, slave is the RAM.
interface bram_sdp_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int BIT_WIDTH  = 32
);
    logic [BIT_WIDTH/8-1:0] we;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [BIT_WIDTH-1:0]   wdi;
    logic                   re;
    logic [ADDR_WIDTH-1:0]  raddr;
    logic [BIT_WIDTH-1:0]   rdo;
    logic                   rvalid;
    logic                   err;
    logic                   err_clr;

    modport master (
        output we, waddr, wdi, re, raddr, err_clr,
        input  rdo, rvalid, err
    );

    modport slave (
        input  we, waddr, wdi, re, raddr, err_clr,
        output rdo, rvalid, err
    );
endinterface

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port RAM, byte enables, READ_LAT 1/2.
// BRAM_SDP_BYPASS_EN: write-first collisions (else read-first).
module bram_sdp #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 12,
    parameter int BIT_WIDTH  = 32,
    parameter int READ_LAT   = 1
) (
    input logic       clk,
    input logic       rst_n,
    bram_sdp_if.slave bus
);
    localparam int NB = BIT_WIDTH / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH+1)'(DEPTH);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic                 wr_any;
    logic                 wr_in;
    logic                 rd_in;
    logic                 bad;
    logic [AW-1:0]        widx;
    logic [AW-1:0]        ridx;
    logic [BIT_WIDTH-1:0] rdata;

    logic                 v1;
    logic [BIT_WIDTH-1:0] d1;

    assign wr_any = |bus.we;
    assign wr_in  = wr_any && ({1'b0, bus.waddr} < LIMIT);
    assign rd_in  = bus.re && ({1'b0, bus.raddr} < LIMIT);
    assign bad    = (wr_any && !wr_in) ||
                    (bus.re && !rd_in);
    assign widx   = bus.waddr[AW-1:0];
    assign ridx   = bus.raddr[AW-1:0];

    // array write, enabled byte lanes only; array is never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_in && bus.we[i])
                mem[widx][8*i +: 8] <= bus.wdi[8*i +: 8];
        end
    end

`ifdef BRAM_SDP_BYPASS_EN
    logic hit;
    assign hit = wr_in && rd_in && (bus.waddr == bus.raddr);

    // write-first: merge enabled lanes of wdi over the old word
    always_comb begin
        rdata = mem[ridx];
        for (int i = 0; i < NB; i++) begin
            if (hit && bus.we[i])
                rdata[8*i +: 8] = bus.wdi[8*i +: 8];
        end
    end
`else
    // read-first: colliding read sees the pre-write word
    always_comb begin
        rdata = mem[ridx];
    end
`endif

    // first read stage; out-of-range reads return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= bus.re;
            if (bus.re)
                d1 <= rd_in ? rdata : '0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                 v2;
            logic [BIT_WIDTH-1:0] d2;

            // output stage: advances every cycle, holds data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1)
                        d2 <= d1;
                end
            end

            assign bus.rvalid = v2;
            assign bus.rdo    = d2;
        end else begin : g_lat1
            assign bus.rvalid = v1;
            assign bus.rdo    = d1;
        end
    endgenerate

    // sticky range error; a new fault beats a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.err <= 1'b0;
        else if (bad)
            bus.err <= 1'b1;
        else if (bus.err_clr)
            bus.err <= 1'b0;
    end
endmodule

// File: tb/tb_bram_sdp.sv
// tb_bram_sdp: directed checks on READ_LAT=1 and READ_LAT=2
// instances driven with identical stimulus.
module tb_bram_sdp;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [3:0]  we = '0;
    logic [11:0] waddr = '0;
    logic [31:0] wdi = '0;
    logic        re = 1'b0;
    logic [11:0] raddr = '0;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    bram_sdp_if #(.ADDR_WIDTH(12), .BIT_WIDTH(32)) b1 ();
    bram_sdp_if #(.ADDR_WIDTH(12), .BIT_WIDTH(32)) b2 ();

    assign b1.we = we;
    assign b1.waddr = waddr;
    assign b1.wdi = wdi;
    assign b1.re = re;
    assign b1.raddr = raddr;
    assign b1.err_clr = err_clr;
    assign b2.we = we;
    assign b2.waddr = waddr;
    assign b2.wdi = wdi;
    assign b2.re = re;
    assign b2.raddr = raddr;
    assign b2.err_clr = err_clr;

    bram_sdp #(
        .ADDR_WIDTH(12), .DEPTH(12),
        .BIT_WIDTH(32), .READ_LAT(1)
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );

    bram_sdp #(
        .ADDR_WIDTH(12), .DEPTH(12),
        .BIT_WIDTH(32), .READ_LAT(2)
    ) u_lat2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    always #5 clk = ~clk;

`ifdef BRAM_SDP_BYPASS_EN
    localparam logic [31:0] COL_EXP = 32'h12345678;
`else
    localparam logic [31:0] COL_EXP = 32'h00000000;
`endif

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we = '0;
        re = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a,
                      input logic [31:0] d,
                      input logic [3:0] m);
        waddr = a;
        wdi = d;
        we = m;
        step();
        idle();
    endtask

    task automatic rd_chk(input string tag,
                          input logic [11:0] a,
                          input logic [31:0] exp);
        raddr = a;
        re = 1'b1;
        step();
        idle();
        check({tag, " l1 rvalid"}, 32'(b1.rvalid), 32'd1);
        check({tag, " l1 rdo"}, b1.rdo, exp);
        check({tag, " l2 early"}, 32'(b2.rvalid), 32'd0);
        step();
        check({tag, " l2 rvalid"}, 32'(b2.rvalid), 32'd1);
        check({tag, " l2 rdo"}, b2.rdo, exp);
        check({tag, " l1 strobe"}, 32'(b1.rvalid), 32'd0);
        check({tag, " l1 hold"}, b1.rdo, exp);
    endtask

    initial begin
        #12;
        rst_n = 1'b0;
        #1;
        check("rst l1 rdo", b1.rdo, 32'd0);
        check("rst l1 rvalid", 32'(b1.rvalid), 32'd0);
        check("rst l1 err", 32'(b1.err), 32'd0);
        check("rst l2 rdo", b2.rdo, 32'd0);
        check("rst l2 rvalid", 32'(b2.rvalid), 32'd0);
        check("rst l2 err", 32'(b2.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle l1 rvalid", 32'(b1.rvalid), 32'd0);
        check("idle l2 rvalid", 32'(b2.rvalid), 32'd0);

        wr(12'd3, 32'hDEADBEEF, 4'hF);
        rd_chk("full", 12'd3, 32'hDEADBEEF);

        wr(12'd5, 32'h11223344, 4'hF);
        wr(12'd5, 32'hAABBCCDD, 4'b0101);
        rd_chk("lane", 12'd5, 32'h11BB33DD);
        wr(12'd5, 32'hFFFFFFFF, 4'h0);
        rd_chk("we0", 12'd5, 32'h11BB33DD);

        wr(12'd7, 32'h0, 4'hF);
        waddr = 12'd7;
        wdi = 32'h12345678;
        we = 4'hF;
        raddr = 12'd7;
        re = 1'b1;
        step();
        idle();
        check("col l1", b1.rdo, COL_EXP);
        step();
        check("col l2", b2.rdo, COL_EXP);
        rd_chk("col after", 12'd7, 32'h12345678);

        wr(12'd0, 32'hA5A5A5A5, 4'hF);
        check("err idle", 32'(b1.err), 32'd0);
        wr(12'd12, 32'hFFFFFFFF, 4'h0);
        check("err we0", 32'(b1.err), 32'd0);
        wr(12'd12, 32'hFFFFFFFF, 4'hF);
        check("err wr l1", 32'(b1.err), 32'd1);
        check("err wr l2", 32'(b2.err), 32'd1);
        rd_chk("alias", 12'd0, 32'hA5A5A5A5);
        check("err sticky", 32'(b1.err), 32'd1);
        err_clr = 1'b1;
        step();
        idle();
        check("err clr", 32'(b1.err), 32'd0);
        rd_chk("oor rd", 12'd15, 32'h0);
        check("err rd", 32'(b2.err), 32'd1);
        err_clr = 1'b1;
        raddr = 12'd20;
        re = 1'b1;
        step();
        idle();
        check("err set wins", 32'(b1.err), 32'd1);
        err_clr = 1'b1;
        step();
        idle();
        check("err clr2", 32'(b2.err), 32'd0);

        for (int i = 0; i < 12; i++)
            wr(12'(i), 32'h100 + 32'(i), 4'hF);
        for (int i = 0; i < 14; i++) begin
            re = (i < 12);
            raddr = 12'(i);
            step();
            if (i >= 1 && i <= 12) begin
                check("stream rvalid", 32'(b2.rvalid), 32'd1);
                check("stream rdo", b2.rdo,
                      32'h100 + 32'(i - 1));
            end
            if (i == 13)
                check("stream end", 32'(b2.rvalid), 32'd0);
        end
        idle();

        for (int i = 0; i < 4; i++) begin
            re = 1'b1;
            raddr = 12'(i + 4);
            step();
        end
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        check("mid rst l1", 32'(b1.rvalid), 32'd0);
        check("mid rst l2", 32'(b2.rvalid), 32'd0);
        check("mid rst rdo", b2.rdo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post rst l1", 32'(b1.rvalid), 32'd0);
        check("post rst l2", 32'(b2.rvalid), 32'd0);
        step();
        check("post rst l2b", 32'(b2.rvalid), 32'd0);
        check("post rst rdo", b2.rdo, 32'd0);
        rd_chk("post rst rd", 12'd11, 32'h10B);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
